// File: rtl/coin_acceptor_pkg.sv
// ---------------------------------------------------------------------------
// coin_acceptor_pkg
//   Shared types for the coin acceptor slice of the vending datapath.
//   money_t      : value carried on sigCash toward shopping.
//   coin_state_t : control states of the coin acceptor FSM.
// ---------------------------------------------------------------------------
package coin_acceptor_pkg;

    typedef enum logic [1:0] {
        CASH_NONE = 2'd0,
        CASH_5    = 2'd1,
        CASH_10   = 2'd2
    } money_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EMIT         = 2'd1,
        REJECT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } coin_state_t;

endpackage

// File: rtl/coin_acceptor_debouncer.sv
// ---------------------------------------------------------------------------
// coin_acceptor_debouncer
//   Two-flop synchronizer followed by a stability counter for one raw,
//   bouncing switch. The debounced level only changes after the synchronized
//   input has differed from it for DEBOUNCE_CYCLES consecutive samples.
//
//   Ports
//     clk   in   system clock
//     rst   in   asynchronous, active-low reset
//     din   in   raw switch, asynchronous to clk
//     dout  out  debounced level (registered)
// ---------------------------------------------------------------------------
module coin_acceptor_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // A one-cycle debounce still needs a 1-bit counter to keep widths legal.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            // Any agreeing sample restarts the stability window.
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            level_q <= ~level_q;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
//   Debounces the two coin switches, detects presses, gates them by the
//   acceptance window from shopping and emits one-cycle money_t pulses.
//   Refused coins raise coinReject for one cycle. A saturating counter keeps
//   the number of accepted coins for diagnostics.
//
//   Ports
//     clk         in   system clock
//     rst         in   asynchronous, active-low reset
//     coinBtn5    in   raw 5-unit coin switch (async, bouncing)
//     coinBtn10   in   raw 10-unit coin switch (async, bouncing)
//     acceptEn    in   shopping is in a cash-accepting state
//     sigCash     out  one-cycle coin pulse, CASH_NONE when idle
//     coinReject  out  one-cycle pulse when a coin is refused
//     coinCount   out  saturating count of accepted coins
// ---------------------------------------------------------------------------
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coinBtn5,
    input  logic             coinBtn10,
    input  logic             acceptEn,
    output money_t           sigCash,
    output logic             coinReject,
    output logic [CNT_W-1:0] coinCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic lvl5;
    logic lvl10;
    logic lvl5_q;
    logic lvl10_q;
    logic rise5_q;
    logic rise10_q;

    coin_state_t      state_q;
    coin_state_t      state_d;
    money_t           cash_q;
    money_t           cash_d;
    logic             reject_q;
    logic             reject_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    coin_acceptor_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db5 (
        .clk  (clk),
        .rst  (rst),
        .din  (coinBtn5),
        .dout (lvl5)
    );

    coin_acceptor_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db10 (
        .clk  (clk),
        .rst  (rst),
        .din  (coinBtn10),
        .dout (lvl10)
    );

    // Registered rising-edge detect on the debounced levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl5_q   <= 1'b0;
            lvl10_q  <= 1'b0;
            rise5_q  <= 1'b0;
            rise10_q <= 1'b0;
        end else begin
            lvl5_q   <= lvl5;
            lvl10_q  <= lvl10;
            rise5_q  <= lvl5 & ~lvl5_q;
            rise10_q <= lvl10 & ~lvl10_q;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cash_d   = CASH_NONE;
        reject_d = 1'b0;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (rise5_q && rise10_q) begin
                    // Ambiguous coin: refuse regardless of the window.
                    state_d  = REJECT;
                    reject_d = 1'b1;
                end else if (rise5_q || rise10_q) begin
                    if (acceptEn) begin
                        state_d = EMIT;
                        cash_d  = rise5_q ? CASH_5 : CASH_10;
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        state_d  = REJECT;
                        reject_d = 1'b1;
                    end
                end
            end
            // Outputs for EMIT/REJECT are loaded on entry, so both states last
            // exactly one cycle and then wait for the switches to settle open.
            EMIT:   state_d = WAIT_RELEASE;
            REJECT: state_d = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (!lvl5 && !lvl10) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cash_q   <= CASH_NONE;
            reject_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cash_q   <= cash_d;
            reject_q <= reject_d;
            count_q  <= count_d;
        end
    end

    assign sigCash    = cash_q;
    assign coinReject = reject_q;
    assign coinCount  = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// ---------------------------------------------------------------------------
// tb_coin_acceptor
//   Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4 and CNT_W=2.
//   A press driven just after edge E produces its pulse after edge E+8
//   (sampled at E+1: 2 sync + 4 debounce + rise + output register).
// ---------------------------------------------------------------------------
module tb_coin_acceptor;
    import coin_acceptor_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          coinBtn5  = 1'b0;
    logic          coinBtn10 = 1'b0;
    logic          acceptEn  = 1'b0;
    money_t        sigCash;
    logic          coinReject;
    logic [CW-1:0] coinCount;

    int tests = 0;
    int fails = 0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coinBtn5   (coinBtn5),
        .coinBtn10  (coinBtn10),
        .acceptEn   (acceptEn),
        .sigCash    (sigCash),
        .coinReject (coinReject),
        .coinCount  (coinCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n cycles with no pulse of either kind and a stable count.
    task automatic quiet(input string tag, input int n, input logic [CW-1:0] cnt);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_cash"}, sigCash, CASH_NONE);
            check({tag, "_rej"}, {31'd0, coinReject}, 32'd0);
            check({tag, "_cnt"}, {30'd0, coinCount}, {30'd0, cnt});
        end
    endtask

    // Called right after driving a press; expects silence for 7 edges, the
    // outcome on the 8th, and silence again on the 9th.
    task automatic expect_outcome(input string tag, input money_t cash, input logic rej,
                                  input logic [CW-1:0] cnt_before, input logic [CW-1:0] cnt_after);
        quiet({tag, "_lat"}, 7, cnt_before);
        tick();
        check({tag, "_cash"}, sigCash, cash);
        check({tag, "_rej"}, {31'd0, coinReject}, {31'd0, rej});
        check({tag, "_cnt"}, {30'd0, coinCount}, {30'd0, cnt_after});
        quiet({tag, "_after"}, 1, cnt_after);
    endtask

    initial begin
        // Reset state while rst is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cash", sigCash, CASH_NONE);
        check("rst_rej", {31'd0, coinReject}, 32'd0);
        check("rst_cnt", {30'd0, coinCount}, 32'd0);
        rst = 1'b1;
        quiet("idle", 3, 2'd0);

        // Clean 5-coin held for 20 cycles: one pulse only.
        acceptEn = 1'b1;
        coinBtn5 = 1'b1;
        expect_outcome("clean5", CASH_5, 1'b0, 2'd0, 2'd1);
        quiet("hold5", 11, 2'd1);
        coinBtn5 = 1'b0;
        quiet("rel5", 10, 2'd1);

        // Bounce: 2-cycle glitches never pass; the final stable high does.
        for (int i = 0; i < 6; i++) begin
            coinBtn10 = (i % 2 == 0);
            quiet("bounce_glitch", 2, 2'd1);
        end
        coinBtn10 = 1'b1;
        expect_outcome("bounce10", CASH_10, 1'b0, 2'd1, 2'd2);
        quiet("hold10", 5, 2'd2);
        coinBtn10 = 1'b0;
        quiet("rel10", 10, 2'd2);

        // Closed window: refused, count unchanged; then accepted once open.
        acceptEn = 1'b0;
        coinBtn5 = 1'b1;
        expect_outcome("reject", CASH_NONE, 1'b1, 2'd2, 2'd2);
        coinBtn5 = 1'b0;
        quiet("rel_rej", 10, 2'd2);
        acceptEn = 1'b1;
        coinBtn5 = 1'b1;
        expect_outcome("reopen5", CASH_5, 1'b0, 2'd2, 2'd3);
        coinBtn5 = 1'b0;
        quiet("rel_reopen", 10, 2'd3);

        // Both coins on the same edge: a single reject.
        coinBtn5  = 1'b1;
        coinBtn10 = 1'b1;
        expect_outcome("simul", CASH_NONE, 1'b1, 2'd3, 2'd3);
        coinBtn5  = 1'b0;
        coinBtn10 = 1'b0;
        quiet("rel_simul", 10, 2'd3);

        // Fourth accepted coin saturates; a second switch while one is held
        // is ignored until both are released.
        coinBtn5 = 1'b1;
        expect_outcome("sat4", CASH_5, 1'b0, 2'd3, 2'd3);
        coinBtn10 = 1'b1;
        quiet("second_held", 15, 2'd3);
        coinBtn5  = 1'b0;
        coinBtn10 = 1'b0;
        quiet("rel_sat4", 10, 2'd3);
        coinBtn10 = 1'b1;
        expect_outcome("sat5", CASH_10, 1'b0, 2'd3, 2'd3);
        coinBtn10 = 1'b0;
        quiet("rel_sat5", 10, 2'd3);

        // Asynchronous reset mid-debounce, between clock edges.
        coinBtn5 = 1'b1;
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        check("async_rst_cash", sigCash, CASH_NONE);
        check("async_rst_rej", {31'd0, coinReject}, 32'd0);
        check("async_rst_cnt", {30'd0, coinCount}, 32'd0);
        tick();
        tick();
        check("in_rst_cnt", {30'd0, coinCount}, 32'd0);
        rst = 1'b1;
        // Button still held: a full debounce is needed again.
        expect_outcome("post_rst", CASH_5, 1'b0, 2'd0, 2'd1);
        coinBtn5 = 1'b0;
        quiet("rel_post_rst", 10, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Upstream stage of the vending datapath. Turns the raw, bouncing coin switches on the board into clean one-cycle money_t pulses on sigCash, which the top level passes to shopping.
- Gates coins by the acceptance window that shopping grants.
- Flags rejected coins.
- Keeps a saturating count of accepted coins for diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable samples needed to change a debounced level (10 ms at 100 MHz).
- CNT_W, 8, width of the accepted-coin counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- coinBtn5  input  1  raw switch for the 5-unit coin; asynchronous to clk, bouncing.
- coinBtn10  input  1  raw switch for the 10-unit coin; asynchronous to clk, bouncing.
- acceptEn  input  1  high while shopping is in a cash-accepting state.
- sigCash  output  money_t  one-cycle coin pulse; CASH_NONE when idle.
- coinReject  output  1  one-cycle pulse when a coin is refused.
- coinCount  output  CNT_W  saturating count of accepted coins.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: sigCash=CASH_NONE, coinReject=0, coinCount=0.
  - Internal state: FSM=IDLE; synchronizers, debounce counters and debounced levels all 0.
  - Release of reset is synchronous to clk.
- Synchronizer: each raw input passes through a two-flop synchronizer before any other use.
- Debounce, per input, independently:
  - A counter increments while the synchronized value differs from the debounced level.
  - The counter clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Rise detect: a registered 0→1 edge of each debounced level produces rise5 / rise10 for one cycle.
- FSM (one-hot or binary, implementer's choice):
  - IDLE:
    - rise5 only, acceptEn=1 → EMIT with latched CASH_5.
    - rise10 only, acceptEn=1 → EMIT with latched CASH_10.
    - Any rise with acceptEn=0 → REJECT.
    - rise5 and rise10 in the same cycle → REJECT, regardless of acceptEn.
  - EMIT: sigCash = latched value for exactly one cycle; coinCount increments, saturating at 2^CNT_W-1 (no wrap). Then → WAIT_RELEASE.
  - REJECT: coinReject=1 for exactly one cycle; sigCash stays CASH_NONE. Then → WAIT_RELEASE.
  - WAIT_RELEASE: stays until both debounced levels are 0, then → IDLE. Any rise seen in this state is ignored; at most one pulse per press.
- Latency: a raw input that goes and stays high at clock edge N gives sigCash valid in the cycle after edge N+DEBOUNCE_CYCLES+3. The breakdown is 2 sync stages + DEBOUNCE_CYCLES + rise register + FSM output register. All outputs are registered.
- acceptEn is sampled only in IDLE on a rise. Dropping acceptEn during EMIT does not cancel the pulse already committed.
- A held button produces one pulse and no repeat. A new pulse needs a debounced release followed by a fresh debounced press.
- Reset mid-operation (during debounce, EMIT or WAIT_RELEASE) discards the pending coin; no pulse is emitted after reset.
- sigCash is never anything other than CASH_NONE, CASH_5 or CASH_10.

Decomposition:
- global.svh:
  - money_t carries CASH_NONE, CASH_5, CASH_10.
  - The FSM state type is coin_state_t {IDLE, EMIT, REJECT, WAIT_RELEASE}, declared there as well.
  - Since the simulator will not cast to enums, the FSM register and sigCash register use these declared types directly, never casts from logic vectors.
- Sub-module debouncer (params DEBOUNCE_CYCLES; ports clk, rst, din, dout) contains the synchronizer and debounce counter. It is instantiated twice.
- coin_acceptor contains edge detect, FSM and counter.

Test Plan (bench runs DEBOUNCE_CYCLES=4, so nominal latency is 7 cycles):
- Clean 5-coin: acceptEn=1; coinBtn5 high for 20 cycles → sigCash=CASH_5 for exactly 1 cycle, 7 cycles after the rise. coinCount=1. No further pulse until release.
- Bounce: coinBtn10 toggles every 2 cycles for 12 cycles, then stays high → exactly one CASH_10 pulse, 7 cycles after the final rise. Glitches alone produce nothing.
- Reject window: acceptEn=0; press coinBtn5 → coinReject=1 for one cycle, sigCash stays CASH_NONE, coinCount unchanged. Then acceptEn=1, release, press again → CASH_5 emitted.
- Simultaneous: both buttons rise at the same edge with acceptEn=1 → one coinReject pulse, no sigCash. A second button pressed while the first is held is ignored until both are released.
- Saturation: CNT_W=2 with 5 accepted coins → coinCount reads 1, 2, 3, 3, 3.
- Async reset mid-debounce: assert rst low 2 cycles after the press, unsynchronized to clk → all outputs 0 / CASH_NONE immediately. After release with the button still held, a full debounce is required before a pulse.
